// File: rtl/mem_port_master_if.sv
// Request/response handshake between the control FSM and mem_port_master.
// Latency: none (wires only).
// Backpressure: the requester holds req_* until it sees req_ready high at a clock edge.
//
// Signals:
//   req_valid/req_ready       request handshake
//   req_write/req_inst        store / instruction-fetch qualifiers
//   req_size/req_signed       access width and load extension
//   req_addr/req_wdata        byte address and store data
//   resp_valid/resp_err       one-cycle completion pulse and its error flag
//   resp_rdata                load result (0 for stores and errors)
interface mem_port_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_inst;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;

    // Requester side (control FSM / testbench)
    modport master (
        output req_valid, req_write, req_inst, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_err, resp_rdata
    );

    // Responder side (mem_port_master)
    modport slave (
        input  req_valid, req_write, req_inst, req_size, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_err, resp_rdata
    );
endinterface

// File: rtl/mem_port_master.sv
// Single-outstanding memory port master: fetch/load/store with byte/half RMW stores.
// Latency: error 1 cycle, load/word store 2 cycles, sub-word store 3 cycles (accept edge -> resp_valid).
// Backpressure: req_ready is high only in IDLE; one request in flight, requester must hold req_*.
//
// Ports:
//   clk, reset (async, active-low)
//   req_if      : request/response handshake (slave modport)
//   inst_out    : last successfully fetched instruction
//   Address, Write_data, MemRead, MemWrite : to memory
//   Mem_data    : combinational read data from memory
module mem_port_master #(
    parameter int RAM_SIZE_BIT  = 8,
    parameter int RAM_INST_SIZE = 32,
    parameter int PROTECT_INST  = 1
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_master_if.slave   req_if,
    output logic [31:0]        inst_out,
    output logic [31:0]        Address,
    output logic [31:0]        Write_data,
    output logic               MemRead,
    output logic               MemWrite,
    input  logic [31:0]        Mem_data
);

    typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, RESP} state_t;

    localparam logic [1:0]  SZ_BYTE = 2'b00;
    localparam logic [1:0]  SZ_HALF = 2'b01;
    localparam logic [1:0]  SZ_WORD = 2'b10;
    // Any address bit at or above this mask lies outside the memory.
    localparam logic [31:0] ADDR_HI_MASK = ~((32'd1 << (RAM_SIZE_BIT + 2)) - 32'd1);
    localparam logic [29:0] INST_WORDS   = 30'(RAM_INST_SIZE);

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic        inst_q, inst_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] data_q, data_d;
    logic [31:0] address_q, address_d;
    logic [31:0] write_data_q, write_data_d;
    logic [31:0] inst_out_q, inst_out_d;

    logic        req_err;
    logic [31:0] merged;
    logic [31:0] lane_mask;
    logic [31:0] lane_ins;
    logic [31:0] shifted;
    logic [31:0] load_val;

    // Acceptance-time checks; any hit short-circuits to RESP with no memory access.
    always_comb begin
        req_err = 1'b0;
        if (req_if.req_size == 2'b11)                                   req_err = 1'b1;
        if (req_if.req_size == SZ_WORD && req_if.req_addr[1:0] != 2'b00) req_err = 1'b1;
        if (req_if.req_size == SZ_HALF && req_if.req_addr[0])            req_err = 1'b1;
        if (|(req_if.req_addr & ADDR_HI_MASK))                          req_err = 1'b1;
        if (req_if.req_inst && (req_if.req_write || req_if.req_size != SZ_WORD)) req_err = 1'b1;
        if ((PROTECT_INST != 0) && req_if.req_write && (req_if.req_addr[31:2] < INST_WORDS))
            req_err = 1'b1;
    end

    // Lane replacement for read-modify-write, applied to the word being read this cycle.
    always_comb begin
        lane_mask = 32'hFFFF_FFFF;
        lane_ins  = wdata_q;
        if (size_q == SZ_BYTE) begin
            lane_mask = 32'h0000_00FF << {lane_q, 3'b000};
            lane_ins  = {4{wdata_q[7:0]}};
        end else if (size_q == SZ_HALF) begin
            lane_mask = 32'h0000_FFFF << {lane_q[1], 4'b0000};
            lane_ins  = {2{wdata_q[15:0]}};
        end
        merged = (Mem_data & ~lane_mask) | (lane_ins & lane_mask);
    end

    // Load lane extraction and extension from the captured word.
    always_comb begin
        shifted  = data_q >> {lane_q, 3'b000};
        load_val = data_q;
        if (size_q == SZ_BYTE)
            load_val = {{24{signed_q & shifted[7]}}, shifted[7:0]};
        else if (size_q == SZ_HALF)
            load_val = {{16{signed_q & shifted[15]}}, shifted[15:0]};
    end

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        inst_d       = inst_q;
        size_d       = size_q;
        signed_d     = signed_q;
        lane_d       = lane_q;
        wdata_d      = wdata_q;
        err_d        = err_q;
        data_d       = data_q;
        address_d    = address_q;
        write_data_d = write_data_q;
        inst_out_d   = inst_out_q;
        case (state_q)
            IDLE: begin
                if (req_if.req_valid) begin
                    write_d      = req_if.req_write;
                    inst_d       = req_if.req_inst;
                    size_d       = req_if.req_size;
                    signed_d     = req_if.req_signed;
                    lane_d       = req_if.req_addr[1:0];
                    wdata_d      = req_if.req_wdata;
                    err_d        = req_err;
                    address_d    = {req_if.req_addr[31:2], 2'b00};
                    write_data_d = req_if.req_wdata;
                    if (req_err)                      state_d = RESP;
                    else if (!req_if.req_write)       state_d = RD;
                    else if (req_if.req_size == SZ_WORD) state_d = WR;
                    else                              state_d = RMW_RD;
                end
            end
            RD: begin
                data_d = Mem_data;
                // Update here so inst_out already shows the fetched word during RESP.
                if (inst_q) inst_out_d = Mem_data;
                state_d = RESP;
            end
            WR:     state_d = RESP;
            RMW_RD: begin
                data_d       = Mem_data;
                write_data_d = merged;
                state_d      = RMW_WR;
            end
            RMW_WR: state_d = RESP;
            RESP:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            inst_q       <= 1'b0;
            size_q       <= 2'b00;
            signed_q     <= 1'b0;
            lane_q       <= 2'b00;
            wdata_q      <= '0;
            err_q        <= 1'b0;
            data_q       <= '0;
            address_q    <= '0;
            write_data_q <= '0;
            inst_out_q   <= '0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            inst_q       <= inst_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            lane_q       <= lane_d;
            wdata_q      <= wdata_d;
            err_q        <= err_d;
            data_q       <= data_d;
            address_q    <= address_d;
            write_data_q <= write_data_d;
            inst_out_q   <= inst_out_d;
        end
    end

    // Strobes decode directly from the state flop, so an async reset drops them at once
    // and they can never be high together.
    assign MemRead    = (state_q == RD) || (state_q == RMW_RD);
    assign MemWrite   = (state_q == WR) || (state_q == RMW_WR);
    assign Address    = address_q;
    assign Write_data = write_data_q;
    assign inst_out   = inst_out_q;

    assign req_if.req_ready  = (state_q == IDLE);
    assign req_if.resp_valid = (state_q == RESP);
    assign req_if.resp_err   = (state_q == RESP) && err_q;
    assign req_if.resp_rdata = ((state_q == RESP) && !err_q && !write_q) ? load_val : 32'h0;

endmodule

// File: tb/tb_mem_port_master.sv
// Directed bench for mem_port_master with a 256-word memory model.
// Latency: checks resp_valid at 1/2/3 cycles after acceptance.
// Backpressure: one request at a time; waits for resp_valid with a bounded cycle budget.
module tb_mem_port_master;
    logic        clk;
    logic        reset;
    logic [31:0] inst_out;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Mem_data;

    int vectors    = 0;
    int miscompares = 0;

    mem_port_master_if bus ();

    mem_port_master #(.RAM_SIZE_BIT(8), .RAM_INST_SIZE(32), .PROTECT_INST(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_if     (bus.slave),
        .inst_out   (inst_out),
        .Address    (Address),
        .Write_data (Write_data),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Mem_data   (Mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational read, word write at the rising edge.
    logic [31:0] mem [256];
    bit          mem_loaded = 1'b0;
    assign Mem_data = mem[Address[9:2]];
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[0]     <= 32'h2004_0005;
            mem_loaded <= 1'b1;
        end else if (MemWrite) begin
            mem[Address[9:2]] <= Write_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Results of the last request
    int          lat, rd_n, wr_n;
    logic        r_err, both_hi, order_bad, rdy_in_resp;
    logic [31:0] r_data, r_inst;

    task automatic do_req(input logic wr, input logic inst, input logic [1:0] sz,
                          input logic sgn, input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_inst   = inst;
        bus.req_size   = sz;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0; rd_n = 0; wr_n = 0;
        r_err = 1'b0; both_hi = 1'b0; order_bad = 1'b0; rdy_in_resp = 1'b1;
        r_data = 32'hxxxx_xxxx; r_inst = 32'hxxxx_xxxx;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (MemRead) rd_n++;
            if (MemWrite) begin
                wr_n++;
                if (sz != 2'b10 && rd_n == 0) order_bad = 1'b1;
            end
            if (MemRead && MemWrite) both_hi = 1'b1;
            if (bus.resp_valid) begin
                lat         = c;
                r_err       = bus.resp_err;
                r_data      = bus.resp_rdata;
                r_inst      = inst_out;
                rdy_in_resp = bus.req_ready;
                break;
            end
        end
    endtask

    task automatic chk_req(input string tag, input int e_lat, input int e_rd, input int e_wr,
                           input logic e_err, input logic [31:0] e_data);
        chk({tag, ".lat"},   32'(lat),  32'(e_lat));
        chk({tag, ".rd"},    32'(rd_n), 32'(e_rd));
        chk({tag, ".wr"},    32'(wr_n), 32'(e_wr));
        chk({tag, ".err"},   {31'd0, r_err}, {31'd0, e_err});
        chk({tag, ".rdata"}, r_data, e_data);
        chk({tag, ".both"},  {31'd0, both_hi | order_bad}, 32'd0);
        chk({tag, ".ready"}, {31'd0, rdy_in_resp}, 32'd0);
    endtask

    initial begin
        reset          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_inst   = 1'b0;
        bus.req_size   = 2'b10;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst.MemRead",    {31'd0, MemRead},  32'd0);
        chk("rst.MemWrite",   {31'd0, MemWrite}, 32'd0);
        chk("rst.Address",    Address,    32'h0);
        chk("rst.Write_data", Write_data, 32'h0);
        chk("rst.inst_out",   inst_out,   32'h0);
        chk("rst.resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst.resp_rdata", bus.resp_rdata, 32'h0);
        reset = 1'b1;
        #1 chk("rst.ready", {31'd0, bus.req_ready}, 32'd1);

        // Instruction fetch
        do_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0000, 32'h0);
        chk_req("fetch", 2, 1, 0, 1'b0, 32'h2004_0005);
        chk("fetch.inst_out", r_inst, 32'h2004_0005);

        // Word store then load
        do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF);
        chk_req("st_w", 2, 0, 1, 1'b0, 32'h0);
        chk("st_w.mem", mem[64], 32'hDEAD_BEEF);
        do_req(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0);
        chk_req("ld_w", 2, 1, 0, 1'b0, 32'hDEAD_BEEF);
        chk("ld_w.inst_hold", r_inst, 32'h2004_0005);

        // Byte store via RMW; upper wdata bits must be ignored
        do_req(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0101, 32'h1234_5680);
        chk_req("st_b", 3, 1, 1, 1'b0, 32'h0);
        chk("st_b.mem", mem[64], 32'hDEAD_80EF);

        do_req(1'b0, 1'b0, 2'b00, 1'b1, 32'h0000_0101, 32'h0);
        chk_req("ld_bs", 2, 1, 0, 1'b0, 32'hFFFF_FF80);
        do_req(1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_0101, 32'h0);
        chk_req("ld_bu", 2, 1, 0, 1'b0, 32'h0000_0080);
        do_req(1'b0, 1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0);
        chk_req("ld_hs", 2, 1, 0, 1'b0, 32'hFFFF_DEAD);
        do_req(1'b0, 1'b0, 2'b01, 1'b1, 32'h0000_0100, 32'h0);
        chk_req("ld_hs_pos", 2, 1, 0, 1'b0, 32'hFFFF_80EF);

        // Half store via RMW into upper lane
        do_req(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'hAAAA_1234);
        chk_req("st_h", 3, 1, 1, 1'b0, 32'h0);
        chk("st_h.mem", mem[64], 32'h1234_80EF);

        // Rejected requests
        do_req(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0);
        chk_req("err_align", 1, 0, 0, 1'b1, 32'h0);
        do_req(1'b0, 1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0);
        chk_req("err_size", 1, 0, 0, 1'b1, 32'h0);
        do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'hFFFF_FFFF);
        chk_req("err_prot", 1, 0, 0, 1'b1, 32'h0);
        chk("err_prot.mem", mem[1], 32'h0);
        do_req(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0);
        chk_req("err_range", 1, 0, 0, 1'b1, 32'h0);
        do_req(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0000, 32'h0);
        chk_req("err_fetch_sz", 1, 0, 0, 1'b1, 32'h0);
        chk("err.inst_hold", r_inst, 32'h2004_0005);

        // Reset in the middle of the RMW write cycle
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_inst   = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h0000_0100;
        bus.req_wdata  = 32'h0000_007F;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (MemWrite) break;
        end
        chk("rstmid.wr_seen", {31'd0, MemWrite}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("rstmid.MemWrite", {31'd0, MemWrite}, 32'd0);
        chk("rstmid.MemRead",  {31'd0, MemRead},  32'd0);
        chk("rstmid.Address",  Address, 32'h0);
        chk("rstmid.inst_out", inst_out, 32'h0);
        @(posedge clk);
        #1 chk("rstmid.mem", mem[64], 32'h1234_80EF);
        @(negedge clk);
        reset = 1'b1;
        #1 chk("rstmid.ready", {31'd0, bus.req_ready}, 32'd1);
        do_req(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0);
        chk_req("post_rst_ld", 2, 1, 0, 1'b0, 32'h1234_80EF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_port_master.md
Name: mem_port_master

Overview:
- Initiator-side controller for the CPU's unified instruction/data memory.
- Accepts one fetch/load/store request at a time from the multicycle control FSM.
- Drives the memory's Address/Write_data/MemRead/MemWrite, captures Mem_data, and returns sign/zero-extended data.
- Implements byte/halfword stores as read-modify-write, because the memory only writes whole words.

Parameters:
- RAM_SIZE_BIT, 8, word-index width of the memory; valid byte addresses are 0 .. 2^(RAM_SIZE_BIT+2)-1.
- RAM_INST_SIZE, 32, number of words, from word 0, that form the instruction region.
- PROTECT_INST, 1, when 1, any store whose word index is < RAM_INST_SIZE is rejected with an error.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous, active-low; 0 resets the block.
- req_valid, input, 1, request present.
- req_ready, output, 1, block can accept a request; high only in IDLE.
- req_write, input, 1, 1 = store, 0 = load/fetch.
- req_inst, input, 1, 1 = instruction fetch; must be a word load.
- req_size, input, 2, 00 = byte, 01 = half, 10 = word, 11 = reserved.
- req_signed, input, 1, sign-extend sub-word loads.
- req_addr, input, 32, byte address.
- req_wdata, input, 32, store data; sub-word data is taken from the low bits.
- resp_valid, output, 1, one-cycle completion pulse.
- resp_err, output, 1, valid with resp_valid; request was rejected.
- resp_rdata, output, 32, load result; 0 for stores and for errors.
- inst_out, output, 32, last successfully fetched instruction; holds its value between fetches.
- Address, output, 32, to memory; word-aligned ({addr[31:2], 2'b00}).
- Write_data, output, 32, to memory.
- MemRead, output, 1, to memory.
- MemWrite, output, 1, to memory.
- Mem_data, input, 32, from memory; combinational read, valid in the same cycle MemRead is high.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; resp_valid=0, resp_err=0, resp_rdata=0, inst_out=0, Address=0, Write_data=0, MemRead=0, MemWrite=0.
  - Reset mid-operation aborts immediately. MemWrite must fall asynchronously, so no write commits at the next edge.
- States:
  - IDLE: req_ready=1. On req_valid=1 at a clk edge, latch all req_* fields and run the checks below.
    - Error → RESP with err=1.
    - Load → RD.
    - Word store → WR.
    - Byte/half store → RMW_RD.
  - RD: MemRead=1 for exactly one cycle. Mem_data is captured into the data register at the exiting edge. → RESP.
  - WR: MemWrite=1 and Write_data=wdata for one cycle; memory commits at the exiting edge. → RESP.
  - RMW_RD: MemRead=1 for one cycle; capture Mem_data. → RMW_WR.
  - RMW_WR: MemWrite=1 with Write_data = captured word with the target lane replaced. → RESP.
  - RESP: resp_valid=1 for one cycle, together with resp_err and resp_rdata. → IDLE.
    - req_ready is 0 in this state, so the next request is accepted no earlier than the following cycle.
- Error checks, all evaluated at acceptance; on error, no memory access occurs and MemRead/MemWrite stay 0:
  - req_size=11.
  - Word request with addr[1:0]≠0.
  - Half request with addr[0]≠0.
  - Any addr bit above RAM_SIZE_BIT+1 is set.
  - req_inst=1 with req_write=1 or req_size≠10.
  - PROTECT_INST=1 and a store to a word index < RAM_INST_SIZE.
- Latency from the acceptance edge to resp_valid:
  - Error: 1 cycle.
  - Load and word store: 2 cycles.
  - Sub-word store: 3 cycles.
- Lane mapping is little-endian.
  - Byte k = addr[1:0] occupies bits [8k+7:8k].
  - Half h = addr[1] occupies bits [16h+15:16h].
  - Loads: extracted lane is sign-extended if req_signed, else zero-extended. Word loads return the full word.
- inst_out updates from the captured word at RESP only for a successful fetch. It holds across data accesses and errors.
- Address and Write_data are registered; they may hold stale values while MemRead=MemWrite=0.
- MemRead and MemWrite are never high in the same cycle.
- req_* fields are ignored whenever req_ready=0.

Test Plan:
- Reset: reset=0 asserted mid-RMW_WR → MemWrite drops to 0 without waiting for clk; the target word is unchanged; req_ready=1 after reset=1.
- Fetch: req_inst=1, word read at 0x0 with memory word 0x20040005 → resp_valid 2 cycles after acceptance; resp_rdata=inst_out=0x20040005; exactly one MemRead cycle.
- Word store/load: store 0xDEADBEEF to 0x100, then load word 0x100 → MemWrite pulse lasts one cycle; the load returns 0xDEADBEEF.
- Byte store (RMW): byte store 0x80 to 0x101 on word 0xDEADBEEF → sequence RMW_RD, RMW_WR; memory becomes 0xDEAD80EF; signed byte load of 0x101 → 0xFFFFFF80; unsigned → 0x00000080.
- Half load: signed half load of 0x102 on word 0xDEAD80EF → 0xFFFFDEAD.
- Errors: word load at 0x102; req_size=11; store to 0x04 with PROTECT_INST=1; load at 0x400 → each gives resp_err=1 and resp_rdata=0 one cycle after acceptance, with MemRead=MemWrite=0 throughout.
